mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 10, word-address width.
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter MAX_WAIT, default 2, max consecutive cycles the instruction requester may lose arbitration; legal range 1..15.
REQ-004 Clock and reset SHALL be: one clock; reset is asynchronous and active-low (ports CLK, RSTn).
REQ-005 CLK  input  1  rising-edge clock.
REQ-006 RSTn  input  1  asynchronous active-low reset.
REQ-007 i_req  input  1  instruction read request, held until i_gnt.
REQ-008 i_addr  input  AW  instruction word address.
REQ-009 i_gnt  output  1  instruction request accepted this cycle.
REQ-010 i_rvalid  output  1  i_rdata valid.
REQ-011 i_rdata  output  DW  instruction read data.
REQ-012 d_req  input  1  data request, held with stable fields until d_gnt.
REQ-013 d_we  input  1  1 = write, 0 = read.
REQ-014 d_addr  input  AW  data word address.
REQ-015 d_wdata  input  DW  write data.
REQ-016 d_gnt  output  1  data request accepted this cycle.
REQ-017 d_rvalid  output  1  d_rdata valid.
REQ-018 d_rdata  output  DW  data read data.
REQ-019 m_en  output  1  memory access enable.
REQ-020 m_we  output  1  memory write enable.
REQ-021 m_addr  output  AW  memory word address.
REQ-022 m_wdata  output  DW  memory write data.
REQ-023 m_rdata  input  DW  memory read data, valid one cycle after m_en with m_we=0.

Function
REQ-024 Arbitration SHALL be combinational within the cycle; at most one of i_gnt, d_gnt SHALL be 1 per cycle.
REQ-025 Only i_req: i_gnt=1. Only d_req: d_gnt=1. Neither: no grant, m_en=0.
REQ-026 Both requesting: d_gnt=1 while wait_cnt < MAX_WAIT; i_gnt=1 when wait_cnt == MAX_WAIT.
REQ-027 wait_cnt (4-bit register): increments when i_req=1 and i_gnt=0; clears when i_gnt=1 or i_req=0; never exceeds MAX_WAIT.
REQ-028 On a grant, m_en=1, m_addr=granted address; m_we=d_we for data grant, 0 for instruction grant; m_wdata=d_wdata on data grant, else 0.
REQ-029 Read latency exactly 1 cycle: cycle after an instruction grant, i_rvalid=1 and i_rdata=m_rdata; cycle after a data read grant, d_rvalid=1 and d_rdata=m_rdata.
REQ-030 Data write grant SHALL produce no d_rvalid.
REQ-031 Response routing SHALL use a registered tag (none/instr/data-read) captured at the grant edge; rdata outputs SHALL be 0 when their rvalid=0.
REQ-032 Back-to-back grants SHALL be supported every cycle (full throughput, no bubble); a new grant may coincide with the previous grant's rvalid.
REQ-033 i_addr/d_addr changes while not granted SHALL have no side effect.

Reset
REQ-034 RSTn=0 SHALL immediately force wait_cnt=0, response tag=none, i_rvalid=d_rvalid=0, i_rdata=d_rdata=0, and all grants and m_en/m_we low regardless of requests.
REQ-035 Reset asserted in the cycle after a read grant SHALL suppress that rvalid; no response is delivered after reset release for pre-reset grants.
REQ-036 First cycle after RSTn rises SHALL arbitrate normally with wait_cnt=0.

Verification
REQ-037 i_req=1, i_addr=0x004, mem[4]=0x00500093 -> i_gnt=1, m_en=1, m_we=0, m_addr=0x004; next cycle i_rvalid=1, i_rdata=0x00500093.
REQ-038 d_req=1, d_we=1, d_addr=0x010, d_wdata=0xDEADBEEF -> d_gnt=1, m_we=1, m_wdata=0xDEADBEEF; next cycle d_rvalid=0; later data read of 0x010 returns 0xDEADBEEF.
REQ-039 i_req and d_req held high continuously, MAX_WAIT=2 -> grant pattern D,D,I,D,D,I; never two grants in one cycle.
REQ-040 Alternating instr read then data read on consecutive cycles -> i_rvalid and d_rvalid each one cycle after own grant, no mixing of rdata.
REQ-041 RSTn pulsed low in cycle after a data read grant -> d_rvalid stays 0, wait_cnt=0, all outputs 0 during reset.
REQ-042 i_req only, d_req toggling 1/0 each cycle -> wait_cnt clears on each i_gnt; instruction granted at least once every MAX_WAIT+1 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between an instruction and a data requester
module mem_arbiter #(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 2
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);
    typedef enum logic [1:0] {TAG_NONE, TAG_INSTR, TAG_DATA} tag_t;
    localparam logic [3:0] MW = 4'(MAX_WAIT);
    logic [3:0] wait_cnt_q, wait_cnt_d;
    tag_t       tag_q, tag_d;
    logic       i_win;
    // Data wins contention until the instruction side has waited MAX_WAIT cycles; reset masks all grants
    always_comb begin
        i_win      = wait_cnt_q == MW;
        i_gnt      = RSTn & i_req & (~d_req | i_win);
        d_gnt      = RSTn & d_req & ~(i_req & i_win);
        m_en       = i_gnt | d_gnt;
        m_we       = d_gnt & d_we;
        m_addr     = i_gnt ? i_addr : d_gnt ? d_addr : '0;
        m_wdata    = d_gnt ? d_wdata : '0;
        wait_cnt_d = (i_req & ~i_gnt) ? (i_win ? wait_cnt_q : wait_cnt_q + 4'd1) : 4'd0;
        tag_d      = i_gnt ? TAG_INSTR : (d_gnt & ~d_we) ? TAG_DATA : TAG_NONE;
        i_rvalid   = tag_q == TAG_INSTR;
        d_rvalid   = tag_q == TAG_DATA;
        i_rdata    = i_rvalid ? m_rdata : '0;
        d_rdata    = d_rvalid ? m_rdata : '0;
    end
    // Starvation counter and the tag that routes next cycle's read data
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wait_cnt_q <= 4'd0;
            tag_q      <= TAG_NONE;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            tag_q      <= tag_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a queue-based response scoreboard
module tb_mem_arbiter;
    logic        CLK, RSTn;
    logic        i_req, i_gnt, i_rvalid;
    logic [9:0]  i_addr;
    logic [31:0] i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic        m_en, m_we;
    logic [9:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;
    logic [31:0] mem [1024];

    typedef struct {int due; logic [31:0] data;} exp_t;
    exp_t q [2][$];
    int checks = 0, errors = 0, cyc = 0;
    logic        mv, ev;
    logic [31:0] mr, er;

    mem_arbiter #(.AW(10), .DW(32), .MAX_WAIT(2)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    initial CLK = 0;
    always #5 CLK = ~CLK;

    // memory with one-cycle read latency
    always @(posedge CLK) begin
        if (m_en) begin
            if (m_we) mem[m_addr] <= m_wdata;
            else m_rdata <= mem[m_addr];
        end
    end

    // monitor: compares responses against the scoreboard queues
    always begin
        @(posedge CLK);
        cyc++;
        #2;
        for (int p = 0; p < 2; p++) begin
            mv = p ? d_rvalid : i_rvalid;
            mr = p ? d_rdata : i_rdata;
            ev = q[p].size() > 0 && q[p][0].due == cyc;
            er = ev ? q[p][0].data : 32'h0;
            checks++;
            if ({mv, mr} !== {ev, er}) begin
                errors++;
                $display("FAIL %s_resp cyc %0d: got rvalid=%0b rdata=%h, expected rvalid=%0b rdata=%h",
                         p ? "d" : "i", cyc, mv, mr, ev, er);
            end
            if (ev) void'(q[p].pop_front());
        end
    end

    task automatic check_zero(input string nm);
        checks++;
        if ({i_gnt, d_gnt, m_en, m_we, i_rvalid, d_rvalid, i_rdata, d_rdata} !== '0) begin
            errors++;
            $display("FAIL %s: got gnt=%0b%0b m_en=%0b m_we=%0b rvalid=%0b%0b i_rdata=%h d_rdata=%h, expected all 0",
                     nm, i_gnt, d_gnt, m_en, m_we, i_rvalid, d_rvalid, i_rdata, d_rdata);
        end
    endtask

    // drives one cycle starting at a negedge, checks the grant, queues the expected response
    task automatic drv(input logic ir, input logic [9:0] ia, input logic dr, input logic dw,
                       input logic [9:0] da, input logic [31:0] wd, input logic eg_i, input logic eg_d,
                       input logic [31:0] ed, input string nm, input bit rst_after = 0);
        logic [9:0] ea;
        i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = wd;
        #1;
        ea = eg_i ? ia : da;
        checks++;
        if ({i_gnt, d_gnt, m_en, m_we, m_wdata} !== {eg_i, eg_d, eg_i | eg_d, eg_d & dw, eg_d ? wd : 32'h0}) begin
            errors++;
            $display("FAIL %s: got i_gnt=%0b d_gnt=%0b m_en=%0b m_we=%0b m_wdata=%h, expected %0b %0b %0b %0b %h",
                     nm, i_gnt, d_gnt, m_en, m_we, m_wdata, eg_i, eg_d, eg_i | eg_d, eg_d & dw, eg_d ? wd : 32'h0);
        end
        if (eg_i | eg_d) begin
            checks++;
            if (m_addr !== ea) begin
                errors++;
                $display("FAIL %s_addr: got m_addr=%h, expected %h", nm, m_addr, ea);
            end
        end
        if (eg_i) q[0].push_back('{cyc + 1, ed});
        if (eg_d && !dw && !rst_after) q[1].push_back('{cyc + 1, ed});
        if (rst_after) begin
            @(posedge CLK);
            #1 RSTn = 0;
        end
        @(negedge CLK);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE0000 | i;
        mem[4] = 32'h00500093;
        RSTn = 0; i_req = 1; d_req = 1; d_we = 0; i_addr = 10'h4; d_addr = 10'h8; d_wdata = 32'h0;
        #1 check_zero("reset_start");
        repeat (2) @(negedge CLK);
        check_zero("reset_held");
        RSTn = 1;
        drv(0, 10'h0,  0, 0, 10'h0,  32'h0,        0, 0, 32'h0,        "idle");
        drv(1, 10'h4,  0, 0, 10'h0,  32'h0,        1, 0, 32'h00500093, "ifetch4");
        drv(0, 10'h0,  1, 1, 10'h10, 32'hDEADBEEF, 0, 1, 32'h0,        "dwr10");
        drv(0, 10'h0,  1, 0, 10'h10, 32'h0,        0, 1, 32'hDEADBEEF, "drd10");
        drv(1, 10'h20, 1, 0, 10'h30, 32'h0,        0, 1, 32'hC0DE0030, "both1_d");
        drv(1, 10'h20, 1, 0, 10'h30, 32'h0,        0, 1, 32'hC0DE0030, "both2_d");
        drv(1, 10'h20, 1, 0, 10'h30, 32'h0,        1, 0, 32'hC0DE0020, "both3_i");
        drv(1, 10'h20, 1, 0, 10'h30, 32'h0,        0, 1, 32'hC0DE0030, "both4_d");
        drv(1, 10'h20, 1, 0, 10'h30, 32'h0,        0, 1, 32'hC0DE0030, "both5_d");
        drv(1, 10'h20, 1, 0, 10'h30, 32'h0,        1, 0, 32'hC0DE0020, "both6_i");
        drv(1, 10'h21, 0, 0, 10'h0,  32'h0,        1, 0, 32'hC0DE0021, "alt1_i");
        drv(0, 10'h0,  1, 0, 10'h31, 32'h0,        0, 1, 32'hC0DE0031, "alt2_d");
        drv(1, 10'h22, 0, 0, 10'h0,  32'h0,        1, 0, 32'hC0DE0022, "alt3_i");
        drv(0, 10'h0,  1, 0, 10'h32, 32'h0,        0, 1, 32'hC0DE0032, "alt4_d");
        drv(0, 10'h0,  1, 1, 10'h40, 32'h12345678, 0, 1, 32'h0,        "b2b_wr");
        drv(0, 10'h0,  1, 0, 10'h40, 32'h0,        0, 1, 32'h12345678, "b2b_rd");
        drv(1, 10'h23, 1, 0, 10'h33, 32'h0,        0, 1, 32'hC0DE0033, "clr1_d");
        drv(0, 10'h3FF,1, 0, 10'h33, 32'h0,        0, 1, 32'hC0DE0033, "clr2_d");
        drv(1, 10'h23, 1, 0, 10'h33, 32'h0,        0, 1, 32'hC0DE0033, "clr3_d");
        drv(1, 10'h23, 1, 0, 10'h33, 32'h0,        0, 1, 32'hC0DE0033, "clr4_d");
        drv(1, 10'h23, 1, 0, 10'h33, 32'h0,        1, 0, 32'hC0DE0023, "clr5_i");
        drv(1, 10'h24, 1, 0, 10'h34, 32'h0,        0, 1, 32'hC0DE0034, "tog1_d");
        drv(1, 10'h24, 0, 0, 10'h34, 32'h0,        1, 0, 32'hC0DE0024, "tog2_i");
        drv(1, 10'h24, 1, 0, 10'h34, 32'h0,        0, 1, 32'hC0DE0034, "tog3_d");
        drv(1, 10'h24, 0, 0, 10'h34, 32'h0,        1, 0, 32'hC0DE0024, "tog4_i");
        drv(1, 10'h25, 1, 0, 10'h35, 32'h0,        0, 1, 32'hC0DE0035, "drd_rst", 1);
        check_zero("mid_reset1");
        @(negedge CLK);
        check_zero("mid_reset2");
        RSTn = 1;
        drv(1, 10'h26, 1, 0, 10'h36, 32'h0,        0, 1, 32'hC0DE0036, "post1_d");
        drv(1, 10'h26, 1, 0, 10'h36, 32'h0,        0, 1, 32'hC0DE0036, "post2_d");
        drv(1, 10'h26, 1, 0, 10'h36, 32'h0,        1, 0, 32'hC0DE0026, "post3_i");
        drv(0, 10'h0,  0, 0, 10'h0,  32'h0,        0, 0, 32'h0,        "idle_end1");
        drv(0, 10'h0,  0, 0, 10'h0,  32'h0,        0, 0, 32'h0,        "idle_end2");
        checks++;
        if (q[0].size() + q[1].size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d undelivered responses, expected 0", q[0].size() + q[1].size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
